clk_sched: RTL and testbench
============================

Name: clk_sched

Overview:
- Run/pause/fast-forward controller for the digital clock timebase.
- Debounces the two front-panel buttons and runs a 3-state mode FSM.
- Emits a single-cycle tick enable at either the normal or the quick rate to the time-keeping counters.
- Replaces free-running toggle/quick wiring with one synchronous, glitch-free sequencer.

Parameters:
- DIV_NORMAL, 50000000, clk cycles per tick in RUN (1 Hz at 50 MHz)
- DIV_FAST, 500000, clk cycles per tick in FAST (100 Hz at 50 MHz)
- DEB_CYCLES, 1000000, consecutive stable cycles required to accept a button level change (20 ms)
- CNT_W, 26, width of the tick counter; must hold DIV_NORMAL-1

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- btn_run  in  1  raw run/pause button, active-high, asynchronous to clk
- btn_fast  in  1  raw fast-forward button, active-high, asynchronous to clk
- tick  out  1  one-clk-wide timebase enable
- running  out  1  high in RUN or FAST
- fast  out  1  high in FAST
- state  out  2  FSM state: 00 IDLE, 01 RUN, 10 FAST

Behaviour:
- Reset (rst low, async): state=IDLE; tick=0, running=0, fast=0. Tick counter, synchronizers, debounce counters and debounced levels all clear to 0.
- Input conditioning (per button):
  - 2-FF synchronizer produces sample s.
  - Debounce counter dc and debounced level d. If s==d, dc<=0. Else dc<=dc+1.
  - When dc==DEB_CYCLES-1 and s!=d: d<=s and dc<=0.
  - Any bounce back to d restarts the count.
- Events:
  - run_press: one-cycle pulse on the rising edge of d_run.
  - fast_lvl: equals d_fast.
  - Raw press to run_press latency is 2+DEB_CYCLES clks.
- FSM, registered; the transition takes effect on the edge after the event cycle:
  - IDLE: run_press -> RUN. fast_lvl is ignored.
  - RUN: run_press -> IDLE; else fast_lvl=1 -> FAST.
  - FAST: run_press -> IDLE; else fast_lvl=0 -> RUN.
  - run_press has priority over fast_lvl in the same cycle.
  - Illegal state code 11 -> IDLE on the next edge.
- Outputs running, fast and state are decoded directly from the state register, with no extra latency.
- Tick generation:
  - Active divider: DIV = DIV_FAST in FAST, DIV_NORMAL otherwise.
  - In RUN/FAST, counter cnt increments each clk. When cnt >= DIV-1: tick=1 (registered, one cycle) and cnt<=0.
  - The >= compare means a FAST->RUN or RUN->FAST switch never waits for a counter overflow. If cnt already exceeds the new DIV-1, tick fires on the next edge and cnt wraps.
  - In IDLE: cnt holds its value and tick=0. Pause preserves phase, so resuming RUN continues from the held count.
  - tick is never high for two consecutive cycles. Exception: DIV=1, which is a legal degenerate case where tick is continuously high.
- Reset mid-operation: all state clears immediately, including a partially debounced press. Nothing resumes after rst is released until a new run_press.
- Widths: cnt is CNT_W bits unsigned. DIV_NORMAL, DIV_FAST and DEB_CYCLES are each >=1. Parameter checks flag DIV_NORMAL-1 >= 2^CNT_W.

Test Plan:
(Bench parameters: DIV_NORMAL=10, DIV_FAST=3, DEB_CYCLES=4, CNT_W=8.)
- Reset then idle 50 clks -> tick=0, state=00, running=0, fast=0 throughout.
- Clean btn_run press held 10 clks -> state=01 exactly 2+4+1 clks after the press edge. Ticks then follow every 10 clks; the first tick comes 10 clks after entering RUN.
- btn_run bounce (high 3 clks, low 1, high 3, low) -> no state change. A 5-clk clean press afterwards -> RUN.
- In RUN, hold btn_fast -> state=10 and ticks every 3 clks. On release -> state=01; if cnt was >=9 a tick fires next clk, otherwise ticks continue at period 10.
- RUN with cnt=6, press btn_run -> IDLE and cnt holds 6. Press btn_run again -> RUN and the first tick arrives 4 clks after re-entry.
- run_press and fast_lvl rise in the same cycle while in RUN -> IDLE (priority). Assert rst during FAST -> all outputs 0 asynchronously, and the state stays 00 after release.

Source files
------------

// File: rtl/clk_sched.sv
// Run/pause/fast-forward sequencer for the clock timebase: debounces two
// buttons, runs an IDLE/RUN/FAST mode FSM and emits a one-cycle tick enable.
module clk_sched #(
    parameter int DIV_NORMAL = 50000000,
    parameter int DIV_FAST   = 500000,
    parameter int DEB_CYCLES = 1000000,
    parameter int CNT_W      = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run,
    input  logic       btn_fast,
    output logic       tick,
    output logic       running,
    output logic       fast,
    output logic [1:0] state
);

    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FAST = 2'b10,
        S_ILL  = 2'b11
    } state_t;

    if ((longint'(DIV_NORMAL) - 1) >= (longint'(1) << CNT_W)) begin : g_chk_normal
        $error("clk_sched: CNT_W too narrow for DIV_NORMAL-1");
    end
    if ((longint'(DIV_FAST) - 1) >= (longint'(1) << CNT_W)) begin : g_chk_fast
        $error("clk_sched: CNT_W too narrow for DIV_FAST-1");
    end

    // Index 0 is the run button, index 1 the fast button.
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       deb;
    logic [DEB_W-1:0] dc [2];
    logic             deb_run_prev;
    logic [1:0]       btn_raw;

    assign btn_raw = {btn_fast, btn_run};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1        <= 2'b00;
            sync2        <= 2'b00;
            deb          <= 2'b00;
            dc[0]        <= '0;
            dc[1]        <= '0;
            deb_run_prev <= 1'b0;
        end else begin
            sync1        <= btn_raw;
            sync2        <= sync1;
            deb_run_prev <= deb[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    dc[i] <= '0;
                end else if (dc[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    deb[i] <= sync2[i];
                    dc[i]  <= '0;
                end else begin
                    dc[i] <= dc[i] + 1'b1;
                end
            end
        end
    end

    logic run_press;
    logic fast_lvl;

    assign run_press = deb[0] & ~deb_run_prev;
    assign fast_lvl  = deb[1];

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // run_press wins over fast_lvl when both are present in one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (run_press) state_d = S_RUN;
            S_RUN: begin
                if (run_press)     state_d = S_IDLE;
                else if (fast_lvl) state_d = S_FAST;
            end
            S_FAST: begin
                if (run_press)      state_d = S_IDLE;
                else if (!fast_lvl) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign state   = state_q;
    assign running = (state_q == S_RUN) || (state_q == S_FAST);
    assign fast    = (state_q == S_FAST);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_m1;

    assign div_m1 = (state_q == S_FAST) ? CNT_W'(DIV_FAST - 1) : CNT_W'(DIV_NORMAL - 1);

    // Greater-or-equal compare lets a rate switch wrap immediately when the
    // count already lies beyond the new period; IDLE freezes the phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (running) begin
            if (cnt >= div_m1) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clk_sched.sv
// Directed bench for clk_sched: a step table of {buttons, awaited event,
// expected latency/state/tick count}, plus reset and idle sequences.
module tb_clk_sched;

    logic       clk;
    logic       rst;
    logic       btn_run;
    logic       btn_fast;
    logic       tick;
    logic       running;
    logic       fast;
    logic [1:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    clk_sched #(
        .DIV_NORMAL(10),
        .DIV_FAST  (3),
        .DEB_CYCLES(4),
        .CNT_W     (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_run (btn_run),
        .btn_fast(btn_fast),
        .tick    (tick),
        .running (running),
        .fast    (fast),
        .state   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind 0: run n edges, then check state and tick count
    // kind 1: edges until state==st must equal n; check ticks seen
    // kind 2: edges until tick must equal n; check state
    // kind 3: async reset pulse held n edges; outputs must clear at once
    typedef struct {
        int         kind;
        logic       br;
        logic       bf;
        logic [1:0] st;
        int         n;
        int         t;
    } step_t;

    step_t tab[$];

    task automatic add(input int kind, input logic br, input logic bf,
                       input logic [1:0] st, input int n, input int t);
        step_t s;
        s.kind = kind; s.br = br; s.bf = bf; s.st = st; s.n = n; s.t = t;
        tab.push_back(s);
    endtask

    task automatic chk(input int id, input string what, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL step %0d %s: got %0d, expected %0d", id, what, act, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step_t s;
        int    ticks;
        int    n;
        int    bad;

        rst = 1'b0; btn_run = 1'b0; btn_fast = 1'b0;

        // press/first tick/periods, fast entry & exit, pause with held phase
        add(1, 1, 0, 2'b01, 7, 0);
        add(0, 1, 0, 2'b01, 3, 0);
        add(2, 0, 0, 2'b01, 7, 0);
        add(2, 0, 0, 2'b01, 10, 0);
        add(2, 0, 0, 2'b01, 10, 0);
        add(1, 0, 1, 2'b10, 7, 0);
        add(2, 0, 1, 2'b10, 1, 0);
        add(2, 0, 1, 2'b10, 3, 0);
        add(2, 0, 1, 2'b10, 3, 0);
        add(2, 0, 0, 2'b10, 3, 0);
        add(2, 0, 0, 2'b10, 3, 0);
        add(1, 0, 0, 2'b01, 1, 0);
        add(2, 0, 0, 2'b01, 9, 0);
        add(0, 0, 0, 2'b01, 9, 0);
        add(1, 1, 0, 2'b00, 7, 1);
        add(0, 0, 0, 2'b00, 20, 0);
        add(1, 1, 0, 2'b01, 7, 0);
        add(2, 1, 0, 2'b01, 4, 0);
        add(0, 0, 0, 2'b01, 10, 1);
        // simultaneous run_press and fast_lvl, fast ignored in IDLE
        add(1, 1, 1, 2'b00, 7, 0);
        add(0, 1, 1, 2'b00, 10, 0);
        add(0, 0, 1, 2'b00, 8, 0);
        add(1, 1, 1, 2'b01, 7, 0);
        add(1, 1, 1, 2'b10, 1, 0);
        add(2, 1, 1, 2'b10, 1, 0);
        // reset during FAST, then bounce rejection and a short clean press
        add(3, 0, 0, 2'b00, 3, 0);
        add(0, 0, 0, 2'b00, 30, 0);
        add(0, 1, 0, 2'b00, 3, 0);
        add(0, 0, 0, 2'b00, 1, 0);
        add(0, 1, 0, 2'b00, 3, 0);
        add(0, 0, 0, 2'b00, 12, 0);
        add(0, 1, 0, 2'b00, 5, 0);
        add(1, 0, 0, 2'b01, 2, 0);
        add(2, 0, 0, 2'b01, 10, 0);

        repeat (3) @(posedge clk);
        #1;
        chk(-1, "reset tick", int'(tick), 0);
        chk(-1, "reset running", int'(running), 0);
        chk(-1, "reset fast", int'(fast), 0);
        chk(-1, "reset state", int'(state), 0);
        rst = 1'b1;

        bad = 0;
        for (int k = 0; k < 50; k++) begin
            edge_step();
            bad += int'(tick) + int'(running) + int'(fast) + int'(state != 2'b00);
        end
        chk(-1, "idle activity", bad, 0);

        foreach (tab[i]) begin
            s = tab[i];
            btn_run  = s.br;
            btn_fast = s.bf;
            ticks = 0;
            case (s.kind)
                0: begin
                    repeat (s.n) begin
                        edge_step();
                        ticks += int'(tick);
                    end
                    chk(i, "state", int'(state), int'(s.st));
                    chk(i, "ticks", ticks, s.t);
                end
                1: begin
                    n = -1;
                    for (int k = 1; k <= 200; k++) begin
                        edge_step();
                        ticks += int'(tick);
                        if (state == s.st) begin
                            n = k;
                            break;
                        end
                    end
                    chk(i, "edges to state", n, s.n);
                    chk(i, "ticks", ticks, s.t);
                    chk(i, "running", int'(running), int'(s.st != 2'b00));
                    chk(i, "fast", int'(fast), int'(s.st == 2'b10));
                end
                2: begin
                    n = -1;
                    for (int k = 1; k <= 200; k++) begin
                        edge_step();
                        if (tick) begin
                            n = k;
                            break;
                        end
                    end
                    chk(i, "edges to tick", n, s.n);
                    chk(i, "state", int'(state), int'(s.st));
                end
                default: begin
                    rst = 1'b0;
                    #1;
                    chk(i, "async tick", int'(tick), 0);
                    chk(i, "async running", int'(running), 0);
                    chk(i, "async fast", int'(fast), 0);
                    chk(i, "async state", int'(state), 0);
                    repeat (s.n) edge_step();
                    rst = 1'b1;
                    chk(i, "state in reset", int'(state), int'(s.st));
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
